// File: rtl/display_scroll_pkg.sv
// display_scroll_pkg: shared constants, FSM state type and window packing for the scroll sequencer.
// Holds CSR word offsets, CTRL/STATUS bit positions and the 4-byte window formation function.
// No ports; imported by the interface users and the top level.
package display_scroll_pkg;

  // CSR word offsets
  localparam logic [2:0] CSR_CTRL   = 3'd0;
  localparam logic [2:0] CSR_PERIOD = 3'd1;
  localparam logic [2:0] CSR_DIRECT = 3'd2;
  localparam logic [2:0] CSR_STATUS = 3'd3;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_WRAP_BIT = 1;
  localparam int CTRL_LEN_LSB  = 4;

  // STATUS bit positions
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int STATUS_POS_LSB  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Window at position pos over a message of length len_m1+1.
  // Byte b[(pos+i) mod L] lands in bits [31-8i -: 8], so b[pos] is the MSB byte.
  function automatic logic [31:0] pack_window(input logic [127:0] msg,
                                              input logic [3:0]   pos,
                                              input logic [3:0]   len_m1);
    logic [4:0]  len;
    logic [4:0]  idx;
    logic [31:0] win;
    len = {1'b0, len_m1} + 5'd1;
    win = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ({1'b0, pos} + 5'(i)) % len;
      win[31-8*i -: 8] = msg[{idx[3:0], 3'b000} +: 8];
    end
    return win;
  endfunction

endpackage

// File: rtl/display_scroll_ctrl_if.sv
// display_scroll_ctrl_if: bundles the CSR slave bus and the PIO write-master bus.
// Ports: csr_address/chipselect/write_n/writedata in, csr_readdata out (slave view);
//        pio_address/chipselect/write_n/writedata driven by the sequencer.
interface display_scroll_ctrl_if;
  logic [2:0]  csr_address;
  logic        csr_chipselect;
  logic        csr_write_n;
  logic [31:0] csr_writedata;
  logic [31:0] csr_readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;

  // Sequencer side
  modport slave (
    input  csr_address, csr_chipselect, csr_write_n, csr_writedata,
    output csr_readdata,
    output pio_address, pio_chipselect, pio_write_n, pio_writedata
  );

  // Host / fabric side
  modport master (
    output csr_address, csr_chipselect, csr_write_n, csr_writedata,
    input  csr_readdata,
    input  pio_address, pio_chipselect, pio_write_n, pio_writedata
  );
endinterface

// File: rtl/display_scroll_timer.sv
// display_scroll_timer: down-counter pacing the gap between scroll strobes.
// Ports: clk, reset_n, load/load_val (reload), dec (count enable), expire (count is zero).
// expire is combinational from the count register; load takes priority over dec.
module display_scroll_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_val,
  input  logic                dec,
  output logic                expire
);

  logic [PERIOD_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - PERIOD_W'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/display_scroll_ctrl.sv
// display_scroll_ctrl: scrolls a 16-byte message through a 4-byte window onto the display PIO.
// Ports: clk, reset_n, bus (slave modport: CSR slave in, PIO write master out).
// Host DIRECT writes win the PIO port; a coinciding scroll strobe is retried the next cycle.
module display_scroll_ctrl
  import display_scroll_pkg::*;
#(
  parameter int MSG_BYTES = 16,
  parameter int PERIOD_W  = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  display_scroll_ctrl_if.slave bus
);

  localparam int MSG_WORDS = MSG_BYTES / 4;

  // CSR state
  logic                ctrl_en;
  logic                ctrl_wrap;
  logic [3:0]          ctrl_len_m1;
  logic [PERIOD_W-1:0] period;
  logic [31:0]         msg [MSG_WORDS];
  logic [127:0]        msg_flat;

  // Sequencer state
  state_t              state;
  logic [3:0]          pos;
  logic                done;
  logic                pio_cs_q;
  logic                pio_wn_q;
  logic [31:0]         pio_dat_q;

  // Decode
  logic                csr_wr;
  logic                ctrl_wr;
  logic                direct_wr;
  logic                en_rise;
  logic                stop;
  logic [4:0]          len;
  logic                last_window;
  logic                period_le1;
  logic [3:0]          pos_wrap_next;
  logic [31:0]         window;
  logic                tmr_load;
  logic                tmr_expire;
  logic [31:0]         readdata;

  assign csr_wr    = bus.csr_chipselect && !bus.csr_write_n;
  assign ctrl_wr   = csr_wr && (bus.csr_address == CSR_CTRL);
  assign direct_wr = csr_wr && (bus.csr_address == CSR_DIRECT);
  assign en_rise   = ctrl_wr && bus.csr_writedata[CTRL_EN_BIT] && !ctrl_en;
  // Host clearing EN this cycle stops the scroll without emitting the pending window.
  assign stop      = (ctrl_wr && !bus.csr_writedata[CTRL_EN_BIT]) || !ctrl_en;

  assign len           = {1'b0, ctrl_len_m1} + 5'd1;
  assign last_window   = ({1'b0, pos} + 5'd4) >= len;
  assign period_le1    = (period <= PERIOD_W'(1));
  // A position left beyond a shortened LEN restarts from the beginning.
  assign pos_wrap_next = (({1'b0, pos} + 5'd1) >= len) ? 4'd0 : pos + 4'd1;

  always_comb begin
    msg_flat = '0;
    for (int i = 0; i < MSG_WORDS; i++) begin
      msg_flat[32*i +: 32] = msg[i];
    end
  end

  // LEN and message contents are sampled live, so host edits show on the next window.
  assign window = pack_window(msg_flat, pos, ctrl_len_m1);

  // Reload the gap counter whenever a scroll strobe heads into WAIT. WAIT lasts
  // PERIOD-1 cycles, so the counter starts at PERIOD-2 and WAIT exits on zero.
  assign tmr_load = (state == WRITE) && !stop && !direct_wr && !period_le1 &&
                    (ctrl_wrap || !last_window);

  display_scroll_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (period - PERIOD_W'(2)),
    .dec      (state == WAIT),
    .expire   (tmr_expire)
  );

  // CSR register file (EN lives with the FSM since both sides modify it)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_wrap   <= 1'b0;
      ctrl_len_m1 <= '0;
      period      <= '0;
      for (int i = 0; i < MSG_WORDS; i++) begin
        msg[i] <= '0;
      end
    end else if (csr_wr) begin
      if (bus.csr_address == CSR_CTRL) begin
        ctrl_wrap   <= bus.csr_writedata[CTRL_WRAP_BIT];
        ctrl_len_m1 <= bus.csr_writedata[CTRL_LEN_LSB +: 4];
      end
      if (bus.csr_address == CSR_PERIOD) begin
        period <= bus.csr_writedata[PERIOD_W-1:0];
      end
      if (bus.csr_address[2]) begin
        msg[bus.csr_address[1:0]] <= bus.csr_writedata;
      end
    end
  end

  // Sequencer FSM with registered PIO outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pos       <= '0;
      done      <= 1'b0;
      ctrl_en   <= 1'b0;
      pio_cs_q  <= 1'b0;
      pio_wn_q  <= 1'b1;
      pio_dat_q <= '0;
    end else begin
      pio_cs_q <= 1'b0;
      pio_wn_q <= 1'b1;

      if (direct_wr) begin
        pio_cs_q  <= 1'b1;
        pio_wn_q  <= 1'b0;
        pio_dat_q <= bus.csr_writedata;
      end

      if (ctrl_wr) begin
        ctrl_en <= bus.csr_writedata[CTRL_EN_BIT];
      end

      case (state)
        IDLE: begin
          if (en_rise) begin
            pos   <= '0;
            done  <= 1'b0;
            state <= WRITE;
          end
        end
        WAIT: begin
          if (stop) begin
            state <= IDLE;
          end else if (tmr_expire) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          if (stop) begin
            state <= IDLE;
          end else if (!direct_wr) begin
            // A DIRECT write this cycle holds us in WRITE with POS untouched.
            pio_cs_q  <= 1'b1;
            pio_wn_q  <= 1'b0;
            pio_dat_q <= window;
            if (ctrl_wrap) begin
              pos   <= pos_wrap_next;
              state <= period_le1 ? WRITE : WAIT;
            end else if (last_window) begin
              pos     <= pos + 4'd1;
              done    <= 1'b1;
              ctrl_en <= 1'b0;
              state   <= IDLE;
            end else begin
              pos   <= pos + 4'd1;
              state <= period_le1 ? WRITE : WAIT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational zero-wait-state readback
  always_comb begin
    readdata = '0;
    case (bus.csr_address)
      CSR_CTRL: begin
        readdata[CTRL_EN_BIT]        = ctrl_en;
        readdata[CTRL_WRAP_BIT]      = ctrl_wrap;
        readdata[CTRL_LEN_LSB +: 4]  = ctrl_len_m1;
      end
      CSR_PERIOD: readdata[PERIOD_W-1:0] = period;
      CSR_STATUS: begin
        readdata[STATUS_BUSY_BIT]       = (state != IDLE);
        readdata[STATUS_DONE_BIT]       = done;
        readdata[STATUS_POS_LSB +: 4]   = pos;
      end
      default: begin
        if (bus.csr_address[2]) begin
          readdata = msg[bus.csr_address[1:0]];
        end
      end
    endcase
  end

  assign bus.csr_readdata   = readdata;
  assign bus.pio_address    = 2'd0;
  assign bus.pio_chipselect = pio_cs_q;
  assign bus.pio_write_n    = pio_wn_q;
  assign bus.pio_writedata  = pio_dat_q;

endmodule

// File: tb/tb_display_scroll_ctrl.sv
// tb_display_scroll_ctrl: directed and randomized checks of the scroll sequencer.
// Ports: none; drives the CSR side of the interface and monitors PIO strobes.
// Expected strobe times and data come from the arithmetic window/period rules.
module tb_display_scroll_ctrl;

  logic clk;
  logic reset_n;
  int   cyc;
  int   vectors;
  int   miscompares;

  display_scroll_ctrl_if bus ();

  display_scroll_ctrl #(.MSG_BYTES(16), .PERIOD_W(24)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log: edge index at which the strobe was registered, and its data
  int          sq_cyc[$];
  logic [31:0] sq_dat[$];

  always @(negedge clk) begin
    if (reset_n && bus.pio_chipselect && !bus.pio_write_n) begin
      sq_cyc.push_back(cyc);
      sq_dat.push_back(bus.pio_writedata);
    end
  end

  logic [7:0] mb [16];

  function automatic logic [31:0] exp_win(input int l, input int p);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[31-8*i -: 8] = mb[(p + i) % l];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_t(input logic [2:0] a, input logic [31:0] d, output int t);
    @(negedge clk);
    bus.csr_address = a; bus.csr_writedata = d;
    bus.csr_chipselect = 1'b1; bus.csr_write_n = 1'b0;
    t = cyc + 1;
    @(negedge clk);
    bus.csr_chipselect = 1'b0; bus.csr_write_n = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    int t;
    wr_t(a, d, t);
  endtask

  // Write accepted exactly at posedge number 'target'
  task automatic wr_at(input logic [2:0] a, input logic [31:0] d, input int target);
    while (cyc + 1 < target) @(negedge clk);
    bus.csr_address = a; bus.csr_writedata = d;
    bus.csr_chipselect = 1'b1; bus.csr_write_n = 1'b0;
    @(negedge clk);
    bus.csr_chipselect = 1'b0; bus.csr_write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.csr_address = a; bus.csr_chipselect = 1'b1; bus.csr_write_n = 1'b1;
    #1 d = bus.csr_readdata;
    bus.csr_chipselect = 1'b0;
  endtask

  task automatic load_msg();
    for (int j = 0; j < 4; j++)
      wr(3'(4 + j), {mb[4*j+3], mb[4*j+2], mb[4*j+1], mb[4*j]});
  endtask

  // Start a scroll; wrap runs are stopped by clearing EN after 'hold' cycles.
  task automatic run_scroll(input string tag, input int len, input bit wrap,
                            input int per, input int hold);
    int t0, td, pe, n_exp, nchk;
    logic [31:0] r;
    logic [31:0] ctrl;
    pe = (per < 1) ? 1 : per;
    wr(3'd1, 32'(per));
    sq_cyc.delete(); sq_dat.delete();
    ctrl = (32'(len - 1) << 4) | (32'(wrap) << 1);
    wr_t(3'd0, ctrl | 32'd1, t0);
    if (wrap) begin
      repeat (hold) @(negedge clk);
      wr_t(3'd0, ctrl, td);
      n_exp = 0;
      while (t0 + 1 + n_exp * pe < td) n_exp++;
      rd(3'd3, r);
      chk({tag, "_busy_off"}, 32'(r[0]), 32'd0);
      chk({tag, "_pos"}, 32'(r[11:8]), 32'(n_exp % len));
    end else begin
      n_exp = (len > 3) ? len - 3 : 1;
      repeat (n_exp * pe + 8) @(negedge clk);
      rd(3'd3, r);
      chk({tag, "_done_busy"}, 32'(r[1:0]), 32'd2);
      rd(3'd0, r);
      chk({tag, "_en_clr"}, 32'(r[0]), 32'd0);
    end
    repeat (2 * pe + 4) @(negedge clk);
    chk({tag, "_count"}, 32'(sq_cyc.size()), 32'(n_exp));
    nchk = (sq_cyc.size() < n_exp) ? sq_cyc.size() : n_exp;
    for (int k = 0; k < nchk; k++) begin
      chk($sformatf("%s_t%0d", tag, k), 32'(sq_cyc[k] - t0), 32'(1 + k * pe));
      chk($sformatf("%s_d%0d", tag, k), sq_dat[k], exp_win(len, wrap ? (k % len) : k));
    end
  endtask

  initial begin
    logic [31:0] r;
    int t0, td;
    bit seen;
    vectors = 0; miscompares = 0;
    bus.csr_address = '0; bus.csr_chipselect = 1'b0;
    bus.csr_write_n = 1'b1; bus.csr_writedata = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_write_n", 32'(bus.pio_write_n), 32'd1);
    chk("rst_cs", 32'(bus.pio_chipselect), 32'd0);
    chk("rst_addr", 32'(bus.pio_address), 32'd0);
    chk("rst_wdata", bus.pio_writedata, 32'd0);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), r);
      chk($sformatf("rst_csr%0d", a), r, 32'd0);
    end

    // Directed: bytes 0..15
    for (int k = 0; k < 16; k++) mb[k] = 8'(k);
    load_msg();
    rd(3'd4, r);
    chk("msg0_rb", r, 32'h03020100);
    run_scroll("wrap16", 16, 1'b1, 5, 90);
    chk("win13", exp_win(16, 13), 32'h0D0E0F00);
    run_scroll("nowrap8", 8, 1'b0, 5, 0);

    // DIRECT colliding with the third scroll strobe
    wr(3'd1, 32'd5);
    sq_cyc.delete(); sq_dat.delete();
    wr_t(3'd0, 32'hF3, t0);
    wr_at(3'd2, 32'hDEADBEEF, t0 + 11);
    while (cyc < t0 + 14) @(negedge clk);
    wr_t(3'd0, 32'hF0, td);
    rd(3'd3, r);
    chk("dir_pos", 32'(r[11:8]), 32'd3);
    chk("dir_busy", 32'(r[0]), 32'd0);
    repeat (12) @(negedge clk);
    chk("dir_count", 32'(sq_cyc.size()), 32'd4);
    if (sq_cyc.size() == 4) begin
      chk("dir_t0", 32'(sq_cyc[0] - t0), 32'd1);
      chk("dir_t2", 32'(sq_cyc[2] - t0), 32'd11);
      chk("dir_t3", 32'(sq_cyc[3] - t0), 32'd12);
      chk("dir_d1", sq_dat[1], 32'h01020304);
      chk("dir_d2", sq_dat[2], 32'hDEADBEEF);
      chk("dir_d3", sq_dat[3], 32'h02030405);
    end

    // Randomized runs
    for (int it = 0; it < 8; it++) begin
      int l, p;
      bit w;
      for (int k = 0; k < 16; k++) mb[k] = 8'($urandom);
      load_msg();
      l = $urandom_range(1, 16);
      p = $urandom_range(0, 6);
      w = 1'($urandom);
      run_scroll($sformatf("rnd%0d", it), l, w, p, $urandom_range(10, 60));
    end

    // Reset pulsed while a strobe is on the bus
    for (int k = 0; k < 16; k++) mb[k] = 8'(k);
    load_msg();
    wr(3'd1, 32'd1);
    wr(3'd0, 32'hF3);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = !bus.pio_write_n;
    end
    chk("rst_strobe_seen", 32'(seen), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_write_n", 32'(bus.pio_write_n), 32'd1);
    chk("arst_cs", 32'(bus.pio_chipselect), 32'd0);
    chk("arst_wdata", bus.pio_writedata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(3'd3, r);
    chk("arst_status", r, 32'd0);
    rd(3'd0, r);
    chk("arst_ctrl", r, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_scroll_ctrl.md
# display_scroll_ctrl

Sequencer that drives the left display PIO (32-bit, four 8-bit segment bytes) as an Avalon-MM write master, scrolling a host-loaded message of up to 16 bytes through a 4-byte window at a programmable rate. Sits between the PCIe-bridged Avalon fabric (CSR slave side) and the display PIO's s1 port (master side). Host direct writes share the same PIO port and always win arbitration.

## Interface
Parameters:
- MSG_BYTES, 16, message buffer depth in bytes; fixed at 16, sets the 4-bit position width.
- PERIOD_W, 24, width of the step-period register.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- csr_address  in  3  CSR word select
- csr_chipselect  in  1  CSR select
- csr_write_n  in  1  CSR write strobe, active low
- csr_writedata  in  32  CSR write data
- csr_readdata  out  32  CSR read data, combinational, zero wait states
- pio_address  out  2  PIO address, constant 0
- pio_chipselect  out  1  PIO select, registered
- pio_write_n  out  1  PIO write strobe, active low, registered
- pio_writedata  out  32  PIO write data, registered

## Operation
- CSR map, word offsets:
  - 0 CTRL, RW: bit0 EN, bit1 WRAP, bits[7:4] LEN-1.
  - 1 PERIOD, RW: bits[PERIOD_W-1:0].
  - 2 DIRECT, WO, reads 0.
  - 3 STATUS, RO: bit0 BUSY, bit1 DONE, bits[11:8] POS.
  - 4–7 MSG0–MSG3, RW: byte k of the message is MSG[k/4] bits[8*(k%4)+7 : 8*(k%4)].
- Window at position p: pio_writedata = {b[p], b[p+1 mod L], b[p+2 mod L], b[p+3 mod L]}, with L = LEN and b[p] in bits[31:24].
- FSM states:
  - IDLE: BUSY=0. EN 0→1 clears POS and DONE and goes to WRITE.
  - WRITE: one-cycle PIO strobe of the current window, then POS advances.
    - WRAP=1: POS wraps modulo L.
    - WRAP=0 and POS+4 ≥ L: set DONE, clear EN, go to IDLE.
    - Otherwise go to WAIT.
  - WAIT: count max(PERIOD,1)−1 cycles, then go to WRITE.
- EN cleared by the host in any state: IDLE next cycle, no further scroll strobes, POS unchanged.
- DIRECT write: a PIO strobe carrying csr_writedata is issued the next cycle. It preempts a coinciding scroll WRITE, which is retried the following cycle with POS unchanged. The WAIT counter is not reset.
- MSG and CTRL.LEN writes during scrolling take effect at the next window formation.
- L < 4: the window repeats bytes modulo L. In non-wrap mode, the first write ends the run.

## Timing
- Reset values:
  - pio_chipselect=0, pio_write_n=1, pio_writedata=0, pio_address=0.
  - All CSRs 0, POS=0, FSM in IDLE.
- CSR write accepted at edge T, CTRL.EN rising → first strobe asserted during cycle T+1 to T+2 (active at edge T+2).
- Strobe-to-strobe spacing is exactly max(PERIOD,1) cycles. With PERIOD ≤ 1, strobes are back-to-back.
- DIRECT latency: one cycle from the accepted CSR write to the PIO strobe.
- STATUS reflects registered state; POS updates at the edge ending WRITE.
- Reset assertion mid-strobe deasserts pio_chipselect and pio_write_n asynchronously.

## Structure
- Package display_scroll_pkg:
  - CSR offset constants and CTRL/STATUS bit positions.
  - FSM state enum: IDLE, WAIT, WRITE.
  - Window-packing function.
- Sub-module display_scroll_timer: PERIOD_W down-counter with load and expire outputs.
- Top level holds the CSR file, message buffer, FSM and output arbitration.

## Test plan
- Reset → pio_write_n=1, pio_chipselect=0, csr_readdata=0 at all offsets, STATUS=0.
- MSG0..3 = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; PERIOD=5; CTRL=0xF3 (LEN 16, wrap, EN):
  - strobes 5 cycles apart with data 0x00010203, 0x01020304, …; 14th strobe = 0x0D0E0F00.
  - 17th strobe returns to 0x00010203.
- Same message, CTRL=0x71 (LEN 8, no wrap): five strobes, 0x00010203 through 0x04050607, then DONE=1, BUSY=0, EN=0.
- DIRECT write of 0xDEADBEEF on the same cycle a scroll strobe is due:
  - PIO sees 0xDEADBEEF first, the scroll window one cycle later.
  - POS advances by exactly 1.
- EN cleared during WAIT → no further strobes, STATUS.BUSY=0 next cycle. reset_n pulsed mid-WRITE → outputs return to reset values immediately.
